// File: rtl/sepia_pkg.sv
// Shared types for the sepia frame sequencer: FSM state codes, pixel structs
// and the 9-to-8 bit saturation helper.
package sepia_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_RD_R  = 4'd1;
  localparam state_t ST_RD_G  = 4'd2;
  localparam state_t ST_RD_B  = 4'd3;
  localparam state_t ST_CAP_B = 4'd4;
  localparam state_t ST_SEND  = 4'd5;
  localparam state_t ST_WAIT  = 4'd6;
  localparam state_t ST_WR_R  = 4'd7;
  localparam state_t ST_WR_G  = 4'd8;
  localparam state_t ST_WR_B  = 4'd9;
  localparam state_t ST_DONE  = 4'd10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix8_t;

  typedef struct packed {
    logic [8:0] r;
    logic [8:0] g;
    logic [8:0] b;
  } pix9_t;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/sepia_addr_gen.sv
// Row/column walker for the frame scan; produces the word address of the
// current pixel's R component (rows are stored bottom-up) and a last-pixel flag.
module sepia_addr_gen
  import sepia_pkg::*;
#(
  parameter int HEIGHT = 512,
  parameter int WIDTH  = 768,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              next_i,
  output logic [ADDR_W-1:0] base_o,
  output logic              last_o
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          row_last, col_last;

  assign row_last = (row_q == RW'(HEIGHT - 1));
  assign col_last = (col_q == CW'(WIDTH - 1));
  assign last_o   = row_last && col_last;

  // After the last pixel both counters wrap to zero, ready for the next frame.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (next_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign base_o = (ADDR_W'(HEIGHT - 1) - ADDR_W'(row_q)) * ADDR_W'(3 * WIDTH)
                + ADDR_W'(col_q) * ADDR_W'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/sepia_frame_ctrl.sv
// Frame sequencer: reads each pixel's R/G/B words, hands the pixel to the sepia
// filter, saturates the results and writes them back in place.
module sepia_frame_ctrl
  import sepia_pkg::*;
#(
  parameter int HEIGHT = 512,
  parameter int WIDTH  = 768,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              flt_in_valid,
  input  logic              flt_in_ready,
  output logic [7:0]        flt_in_r,
  output logic [7:0]        flt_in_g,
  output logic [7:0]        flt_in_b,
  input  logic              flt_out_valid,
  input  logic [8:0]        flt_out_r,
  input  logic [8:0]        flt_out_g,
  input  logic [8:0]        flt_out_b,
  output logic [3:0]        dbg_state
);

  state_t            state_q, state_d;
  pix8_t             pix_q, pix_d;
  pix9_t             res_q, res_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              en_q, en_d, we_q, we_d, vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              adv, pix_last;
  logic [ADDR_W-1:0] base;

  sepia_addr_gen #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .next_i (adv),
    .base_o (base),
    .last_o (pix_last)
  );

  // The counter advances in WR_G so the next pixel's base is ready when WR_B
  // computes the following RD_R address; last_q remembers the pixel just written.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    res_d   = res_q;
    last_d  = last_q;
    err_d   = err_q;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RD_R;
      ST_RD_R:  state_d = ST_RD_G;
      ST_RD_G:  begin pix_d.r = mem_rdata; state_d = ST_RD_B;  end
      ST_RD_B:  begin pix_d.g = mem_rdata; state_d = ST_CAP_B; end
      ST_CAP_B: begin pix_d.b = mem_rdata; state_d = ST_SEND;  end
      ST_SEND:  if (flt_in_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (flt_out_valid) begin
          res_d   = '{r: flt_out_r, g: flt_out_g, b: flt_out_b};
          state_d = ST_WR_R;
        end
      end
      ST_WR_R:  state_d = ST_WR_G;
      ST_WR_G:  begin adv = 1'b1; last_d = pix_last; state_d = ST_WR_B; end
      ST_WR_B:  state_d = last_q ? ST_DONE : ST_RD_R;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (flt_out_valid && (state_q != ST_WAIT)) err_d = 1'b1;
    if ((state_q == ST_IDLE) && start) err_d = 1'b0;

    // Outputs are derived from the next state so they register in step with it.
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
    vld_d  = (state_d == ST_SEND);
    we_d   = (state_d == ST_WR_R) || (state_d == ST_WR_G) || (state_d == ST_WR_B);
    en_d   = we_d || (state_d == ST_RD_R) || (state_d == ST_RD_G) || (state_d == ST_RD_B);

    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_d)
      ST_RD_R:          addr_d = base;
      ST_RD_G, ST_RD_B: addr_d = addr_q + 1'b1;
      ST_WR_R: begin addr_d = base;          wdata_d = sat8(res_d.r); end
      ST_WR_G: begin addr_d = addr_q + 1'b1; wdata_d = sat8(res_d.g); end
      ST_WR_B: begin addr_d = addr_q + 1'b1; wdata_d = sat8(res_d.b); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      res_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      res_q   <= res_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      we_q    <= we_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign mem_en       = en_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign flt_in_valid = vld_q;
  assign flt_in_r     = pix_q.r;
  assign flt_in_g     = pix_q.g;
  assign flt_in_b     = pix_q.b;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sepia_frame_ctrl.sv
// Directed bench for sepia_frame_ctrl on a 2x3 frame with a memory model and a
// latency-programmable filter model.
module tb_sepia_frame_ctrl;

  localparam int H  = 2;
  localparam int W  = 3;
  localparam int AW = 5;
  localparam int NW = H * W * 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err, mem_en, mem_we, flt_in_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'd0;
  logic          flt_in_ready;
  logic [7:0]    flt_in_r, flt_in_g, flt_in_b;
  logic          flt_out_valid;
  logic [8:0]    flt_out_r, flt_out_g, flt_out_b;
  logic [3:0]    dbg_state;

  sepia_frame_ctrl #(.HEIGHT(H), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .flt_in_valid(flt_in_valid), .flt_in_ready(flt_in_ready),
    .flt_in_r(flt_in_r), .flt_in_g(flt_in_g), .flt_in_b(flt_in_b),
    .flt_out_valid(flt_out_valid), .flt_out_r(flt_out_r), .flt_out_g(flt_out_g),
    .flt_out_b(flt_out_b), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_now = 0;

  // ---------------- memory model ----------------
  logic [7:0] mem [NW];
  logic       load_req = 1'b0;

  function automatic logic [7:0] init_val(input int i);
    if (i == 9)  return 8'd100;
    if (i == 10) return 8'd150;
    if (i == 11) return 8'd200;
    return 8'(i * 13 + 5);
  endfunction

  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    if (load_req) begin
      for (int i = 0; i < NW; i++) mem[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- filter model ----------------
  int         lat = 2;
  int         hold = 0;
  int         wcnt = 0;
  int         fcnt = 0;
  logic       fov_q = 1'b0;
  logic       inj = 1'b0;
  logic [8:0] res_r = 9'd0, res_g = 9'd0, res_b = 9'd0;

  assign flt_in_ready  = (wcnt >= hold);
  assign flt_out_valid = fov_q | inj;
  assign flt_out_r     = res_r;
  assign flt_out_g     = res_g;
  assign flt_out_b     = res_b;

  always @(posedge clk) begin
    fov_q <= 1'b0;
    if (flt_in_valid && flt_in_ready) begin
      wcnt <= 0;
      if (lat == 1) fov_q <= 1'b1;
      else          fcnt  <= lat - 1;
    end else begin
      if (flt_in_valid) wcnt <= wcnt + 1;
      if (fcnt > 0) begin
        fcnt <= fcnt - 1;
        if (fcnt == 1) fov_q <= 1'b1;
      end
    end
  end

  // ---------------- bus monitors ----------------
  logic [AW-1:0] rd_log [$];
  logic [AW-1:0] wa_log [$];
  logic [7:0]    wd_log [$];
  logic [23:0]   hs_log [$];

  always @(posedge clk) begin
    if (mem_en && !mem_we) rd_log.push_back(mem_addr);
    if (mem_en && mem_we) begin
      wa_log.push_back(mem_addr);
      wd_log.push_back(mem_wdata);
    end
    if (flt_in_valid && flt_in_ready) hs_log.push_back({flt_in_r, flt_in_g, flt_in_b});
  end

  // ---------------- driver tasks ----------------
  task automatic load_mem();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, err, mem_en, mem_we, flt_in_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: busy/done/err/en/we/vld=%b required 000000",
               {busy, done, err, mem_en, mem_we, flt_in_valid});
    end
    total++;
    if ({mem_addr, mem_wdata, flt_in_r, flt_in_g, flt_in_b} !== '0) begin
      bad++;
      $display("FAIL reset_buses: addr=%0d wdata=%0d rgb=%0d/%0d/%0d required all 0",
               mem_addr, mem_wdata, flt_in_r, flt_in_g, flt_in_b);
    end
    total++;
    if (dbg_state !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: state=%0d required 0", dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full frame, ready tied high, L=2: addresses, filter inputs, write data, timing.
  task automatic test_frame();
    logic [AW-1:0] exp_a [$];
    logic [7:0]    exp_q [$];
    logic [23:0]   exp_h [$];
    int r0, w0, h0, fs;
    lat = 2; hold = 0;
    res_r = 9'd192; res_g = 9'd174; res_b = 9'd141;
    load_mem();
    r0 = rd_log.size(); w0 = wa_log.size(); h0 = hs_log.size();
    start_pulse();
    fs = cyc_now;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL frame_busy: busy=%b required 1", busy);
    end
    wait_done(200);
    total++;
    if (cyc_now - fs != 60) begin
      bad++;
      $display("FAIL frame_period: done after %0d cycles required 60", cyc_now - fs);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_busy_in_done: busy=%b required 0", busy);
    end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL done_pulse_width: done/busy=%b required 00", {done, busy});
    end
    repeat (3) @(negedge clk);
    total++;
    if ({busy, mem_en} !== 2'b00) begin
      bad++;
      $display("FAIL start_in_done_ignored: busy/mem_en=%b required 00", {busy, mem_en});
    end

    for (int p = 0; p < H * W; p++) begin
      int b;
      b = W * 3 * (H - 1 - p / W) + 3 * (p % W);
      for (int k = 0; k < 3; k++) exp_a.push_back(AW'(b + k));
      exp_h.push_back({init_val(b), init_val(b + 1), init_val(b + 2)});
      exp_q.push_back(8'd192); exp_q.push_back(8'd174); exp_q.push_back(8'd141);
    end
    total++;
    if (rd_log.size() - r0 != 18 || wa_log.size() - w0 != 18 || hs_log.size() - h0 != 6) begin
      bad++;
      $display("FAIL frame_counts: reads=%0d writes=%0d handshakes=%0d required 18/18/6",
               rd_log.size() - r0, wa_log.size() - w0, hs_log.size() - h0);
    end else begin
      for (int i = 0; i < 18; i++) begin
        total++;
        if (rd_log[r0 + i] !== exp_a[i] || wa_log[w0 + i] !== exp_a[i]) begin
          bad++;
          $display("FAIL frame_addr[%0d]: rd=%0d wr=%0d required %0d",
                   i, rd_log[r0 + i], wa_log[w0 + i], exp_a[i]);
        end
        total++;
        if (wd_log[w0 + i] !== exp_q[i]) begin
          bad++;
          $display("FAIL frame_wdata[%0d]: got %0d required %0d", i, wd_log[w0 + i], exp_q[i]);
        end
      end
      for (int i = 0; i < 6; i++) begin
        total++;
        if (hs_log[h0 + i] !== exp_h[i]) begin
          bad++;
          $display("FAIL frame_pixel_in[%0d]: got %h required %h", i, hs_log[h0 + i], exp_h[i]);
        end
      end
    end
  endtask

  task automatic test_saturation(input logic [8:0] rr, input logic [8:0] rg, input logic [8:0] rb,
                                 input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    int w0;
    res_r = rr; res_g = rg; res_b = rb;
    load_mem();
    w0 = wa_log.size();
    start_pulse();
    wait_done(200);
    total++;
    if (wa_log.size() - w0 != 18) begin
      bad++;
      $display("FAIL sat_count: writes=%0d required 18", wa_log.size() - w0);
    end else begin
      total++;
      if ({wa_log[w0], wa_log[w0 + 1], wa_log[w0 + 2]} !== {AW'(9), AW'(10), AW'(11)}) begin
        bad++;
        $display("FAIL sat_addr: %0d,%0d,%0d required 9,10,11",
                 wa_log[w0], wa_log[w0 + 1], wa_log[w0 + 2]);
      end
      total++;
      if ({wd_log[w0], wd_log[w0 + 1], wd_log[w0 + 2]} !== {e0, e1, e2}) begin
        bad++;
        $display("FAIL sat_data(%0d,%0d,%0d): %0d,%0d,%0d required %0d,%0d,%0d", rr, rg, rb,
                 wd_log[w0], wd_log[w0 + 1], wd_log[w0 + 2], e0, e1, e2);
      end
    end
    @(negedge clk);
  endtask

  // Ready held low for five SEND cycles of every pixel.
  task automatic test_stall();
    logic [23:0] v;
    int n, r0, w0, h0;
    res_r = 9'd192; res_g = 9'd174; res_b = 9'd141;
    hold = 5;
    load_mem();
    r0 = rd_log.size(); w0 = wa_log.size(); h0 = hs_log.size();
    start_pulse();
    n = 0;
    while (flt_in_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    v = {flt_in_r, flt_in_g, flt_in_b};
    total++;
    if (v !== {8'd100, 8'd150, 8'd200}) begin
      bad++;
      $display("FAIL stall_first_pixel: got %h required 6496c8", v);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (flt_in_valid !== 1'b1 || {flt_in_r, flt_in_g, flt_in_b} !== v ||
          flt_in_ready !== (i == 5)) begin
        bad++;
        $display("FAIL stall_hold[%0d]: vld=%b data=%h rdy=%b required 1/%h/%b",
                 i, flt_in_valid, {flt_in_r, flt_in_g, flt_in_b}, flt_in_ready, v, (i == 5));
      end
      @(negedge clk);
    end
    total++;
    if (flt_in_valid !== 1'b0 || hs_log.size() - h0 != 1 || rd_log.size() - r0 != 3) begin
      bad++;
      $display("FAIL stall_single_hs: vld=%b hs=%0d reads=%0d required 0/1/3",
               flt_in_valid, hs_log.size() - h0, rd_log.size() - r0);
    end
    wait_done(300);
    total++;
    if (hs_log.size() - h0 != 6 || rd_log.size() - r0 != 18 || wa_log.size() - w0 != 18) begin
      bad++;
      $display("FAIL stall_totals: hs=%0d reads=%0d writes=%0d required 6/18/18",
               hs_log.size() - h0, rd_log.size() - r0, wa_log.size() - w0);
    end
    hold = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int n, w0, r0, fs;
    load_mem();
    start_pulse();
    n = 0;
    while (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === AW'(10)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL rst_find_wr_g: no write to 10 within 40 cycles");
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({mem_en, mem_we, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL rst_async_drop: en/we/busy/done=%b required 0000", {mem_en, mem_we, busy, done});
    end
    w0 = wa_log.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (wa_log.size() != w0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_writes: extra writes=%0d busy=%b required 0/0", wa_log.size() - w0, busy);
    end
    load_mem();
    r0 = rd_log.size();
    start_pulse();
    fs = cyc_now;
    wait_done(200);
    total++;
    if (rd_log.size() - r0 != 18 || rd_log[r0] !== AW'(9) || cyc_now - fs != 60) begin
      bad++;
      $display("FAIL rst_restart: reads=%0d first=%0d period=%0d required 18/9/60",
               rd_log.size() - r0, rd_log[r0], cyc_now - fs);
    end
    @(negedge clk);
  endtask

  task automatic test_err_and_busy_start();
    int n, w0, fs;
    load_mem();
    w0 = wa_log.size();
    start_pulse();
    fs = cyc_now;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_initial: err=%b required 0", err);
    end
    n = 0;
    while (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === AW'(10)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    inj = 1'b1;
    @(negedge clk) inj = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set: err=%b required 1", err);
    end
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(200);
    total++;
    if (cyc_now - fs != 60 || wa_log.size() - w0 != 18 || wd_log[w0] !== 8'd192 ||
        wd_log[w0 + 17] !== 8'd141) begin
      bad++;
      $display("FAIL err_frame_intact: period=%0d writes=%0d required 60/18",
               cyc_now - fs, wa_log.size() - w0);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({busy, err} !== 2'b01) begin
      bad++;
      $display("FAIL err_sticky_idle: busy/err=%b required 01", {busy, err});
    end
    start_pulse();
    total++;
    if ({busy, err} !== 2'b10) begin
      bad++;
      $display("FAIL err_cleared_by_start: busy/err=%b required 10", {busy, err});
    end
    wait_done(200);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_saturation(9'd344, 9'd306, 9'd238, 8'd255, 8'd255, 8'd238);
    test_saturation(9'd256, 9'd255, 9'd511, 8'd255, 8'd255, 8'd255);
    test_stall();
    test_reset_midframe();
    test_err_and_busy_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sepia_frame_ctrl.md
Name: sepia_frame_ctrl

Overview:
Sequencer that walks a full frame through the external sepia filter datapath and writes the results back in place. It reads R, G, B component words from a single-port frame memory, presents each pixel to the filter over a valid/ready handshake, saturates the filter results to 8 bits, and writes them back. Row order is bottom-up: row 0 is stored in the last memory line. One frame is processed per start pulse.

Parameters:
HEIGHT, 512, frame rows (≥1)
WIDTH, 768, frame columns (≥1)
ADDR_W, 21, frame memory word-address width; must satisfy 2^ADDR_W ≥ HEIGHT*WIDTH*3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to process a frame
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last write
err  out  1  sticky: flt_out_valid seen outside WAIT; cleared by the next accepted start
mem_en  out  1  memory access strobe
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  component word address
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid 1 cycle after a read strobe
flt_in_valid  out  1  pixel offered to filter
flt_in_ready  in  1  filter accepts pixel
flt_in_r/g/b  out  8 each  pixel components
flt_out_valid  in  1  filter result valid
flt_out_r/g/b  in  9 each  unclamped filter results

Behaviour:
- Reset (asynchronous): state IDLE; busy, done, err, mem_en, mem_we, flt_in_valid = 0; mem_addr, mem_wdata, flt_in_* = 0; row/col counters = 0. Memory strobes drop immediately, with no partial write completion. After release, the block waits for a new start.
- All outputs are registered.
- Pixel base address = WIDTH*3*(HEIGHT-1-row) + 3*col. Components are at base+0 (R), +1 (G), +2 (B).
- Scan order: col 0..WIDTH-1 within a row, rows 0..HEIGHT-1.
- FSM:
  - IDLE: start → RD_R, busy=1, err cleared.
  - RD_R, RD_G, RD_B: one read strobe each, at base+0/+1/+2.
  - CAP_B: capture the B data.
  - R is captured in RD_G and G in RD_B, one cycle after each strobe.
  - SEND: flt_in_valid=1 with the captured R/G/B. Valid and data are held stable until flt_in_ready=1. On the handshake cycle → WAIT.
  - WAIT: hold until flt_out_valid=1, then capture the results → WR_R.
  - WR_R, WR_G, WR_B: write strobes to base+0/+1/+2.
  - After WR_B: if last pixel (row=HEIGHT-1, col=WIDTH-1) → DONE, otherwise advance col (wrap to 0 and row+1 at WIDTH-1) → RD_R.
  - DONE: done=1 and busy=0 in this same cycle → IDLE.
- Saturation: each written byte = (result > 255) ? 255 : result[7:0].
- Pixel period = 8 + L cycles, where L is the number of cycles from the accept handshake to flt_out_valid, and L ≥ 1 (flt_out_valid in the handshake cycle is illegal and sets err).
- start while busy: ignored. start in the DONE cycle: ignored.
- flt_out_valid in any state other than WAIT: ignored for data, err set.
- mem_en=0 in IDLE, CAP_B, SEND, WAIT, DONE.

Decomposition:
- Shared package sepia_pkg:
  - state enum (IDLE, RD_R, RD_G, RD_B, CAP_B, SEND, WAIT, WR_R, WR_G, WR_B, DONE)
  - pixel struct {r,g,b} in 8-bit and 9-bit variants
  - function sat8 (9→8 clamp)
- One natural sub-module: sepia_addr_gen, holding the row/col counters, last-pixel flag and base-address computation. It advances on a single "next" strobe.

Test Plan:
1. HEIGHT=2, WIDTH=3, flt_in_ready tied high, L=2 → reads start at addr 9,10,11 for pixel (0,0), and the last pixel uses 6,7,8. Six pixels complete; done pulses 6*10=60 cycles after start accepted.
2. Memory (100,150,200) at 9..11; filter model returns (192,174,141) → writes 192,174,141 to 9,10,11 in order, with mem_we=1 only during WR states.
3. Filter model returns (344,306,238) → writes 255,255,238 (saturation on R and G only).
4. flt_in_ready held low 5 cycles in SEND → flt_in_valid and flt_in_r/g/b stay constant for all 6 cycles. Exactly one handshake occurs; no extra memory strobes.
5. rst_n asserted during WR_G → mem_en, busy, done = 0 immediately. No further writes; the next start restarts at pixel (0,0), addr 9.
6. Pulse start while busy, and pulse flt_out_valid during RD_G → frame unaffected; err=1 until the next accepted start clears it.
